// File: rtl/xbus_timer.sv
// -----------------------------------------------------------------------------
// xbus_timer
//   Prescaled up-counter timer with compare match and a level interrupt.
//   It sits on the XBUS as a slave and answers each access with a one-cycle
//   XDACK.
//
//   Optional feature macro: TIMER_CAPTURE_EN. When it is defined, CAP_IN
//   passes through a synchroniser and a rising edge on it latches COUNT into
//   CAPTURE.
//
// Parameters
//   CNT_W  width of COUNT / COMPARE / CAPTURE (1..32)
//   PRE_W  width of PRESCALE and the internal prescaler (1..32)
//
// Ports
//   CLK     system clock
//   RES     asynchronous active-high reset
//   HLT     debug freeze of the prescaler and the counter (bus still served)
//   XDREQ   bus request, chip-select qualified, held until XDACK
//   XRD     read strobe
//   XWR     write strobe (wins when both strobes are high)
//   XBE     byte enables for writes
//   XADDR   byte address, only [4:2] decoded
//   XATAI   write data
//   XATAO   read data, valid while XDACK is high
//   XDACK   one-cycle access acknowledge
//   XIRQ    level interrupt request
//   CAP_IN  asynchronous capture input (used only with TIMER_CAPTURE_EN)
//
// Register map (word index = XADDR[4:2])
//   0 CTRL      [0]EN [1]IRQEN [2]RELOAD [3]ONESHOT
//   1 PRESCALE  tick every PRESCALE+1 enabled cycles
//   2 COMPARE
//   3 COUNT
//   4 STATUS    [0]MATCH W1C, [1]CAPV W1C (capture build only)
//   5 CAPTURE   read-only (capture build only)
//   6,7         read 0, writes ignored
// -----------------------------------------------------------------------------
module xbus_timer #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        HLT,
    input  logic        XDREQ,
    input  logic        XRD,
    input  logic        XWR,
    input  logic [3:0]  XBE,
    input  logic [31:0] XADDR,
    input  logic [31:0] XATAI,
    output logic [31:0] XATAO,
    output logic        XDACK,
    output logic        XIRQ,
    input  logic        CAP_IN
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic               ack_q;
    logic [31:0]        rdata_q;

    logic               en_q, en_d;
    logic               irqen_q, irqen_d;
    logic               reload_q, reload_d;
    logic               oneshot_q, oneshot_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PRE_W-1:0]   psc_q, psc_d;
    logic [CNT_W-1:0]   cmp_q, cmp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;

    logic               start, do_wr, do_rd, w1c;
    logic [2:0]         idx;
    logic [31:0]        rmux, wmerge;
    logic               run, tick, hit;

`ifdef TIMER_CAPTURE_EN
    // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect
    logic [2:0]         cap_sync_q;
    logic [CNT_W-1:0]   capt_q, capt_d;
    logic               capv_q, capv_d;
    logic               cap_rise;
`else
    logic               unused_cap;
    assign unused_cap = CAP_IN;
`endif

    logic               unused_addr;
    assign unused_addr = ^{XADDR[31:5], XADDR[1:0]};

    // An access is decoded and performed on the edge that moves IDLE -> ACK.
    assign start = (state_q == IDLE) && XDREQ;
    assign do_wr = start && XWR;
    assign do_rd = start && XRD && !XWR;
    assign idx   = XADDR[4:2];
    assign w1c   = do_wr && (idx == 3'd4) && XBE[0];

    assign run   = en_q && !HLT;
    // >= rather than == keeps the prescaler from running away if PRESCALE
    // is lowered below the current prescaler value.
    assign tick  = run && (psc_q >= pre_q);
    assign hit   = tick && (cnt_q == cmp_q);

    // Read mux, zero-extended to 32 bits. It also supplies the old bytes for
    // partial (byte-enabled) writes.
    always_comb begin
        // NOTE: every signal driven from always_comb is given a default first, so no path can infer a latch.
        rmux = '0;
        case (idx)
            3'd0: rmux[3:0]       = {oneshot_q, reload_q, irqen_q, en_q};
            3'd1: rmux[PRE_W-1:0] = pre_q;
            3'd2: rmux[CNT_W-1:0] = cmp_q;
            3'd3: rmux[CNT_W-1:0] = cnt_q;
            3'd4: begin
                rmux[0] = match_q;
`ifdef TIMER_CAPTURE_EN
                rmux[1] = capv_q;
`endif
            end
`ifdef TIMER_CAPTURE_EN
            3'd5: rmux[CNT_W-1:0] = capt_q;
`endif
            default: ;
        endcase
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wmerge[8*b +: 8] = XBE[b] ? XATAI[8*b +: 8] : rmux[8*b +: 8];
        end
    end

    always_comb begin
        en_d      = en_q;
        irqen_d   = irqen_q;
        reload_d  = reload_q;
        oneshot_d = oneshot_q;
        pre_d     = pre_q;
        cmp_d     = cmp_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        psc_d     = psc_q;

        // Tick updates come first so that a software write on the same edge
        // overrides them.
        if (tick) begin
            cnt_d = (hit && reload_q) ? '0 : cnt_q + CNT_W'(1);
        end
        if (hit && oneshot_q) begin
            en_d = 1'b0;
        end

        if (do_wr) begin
            case (idx)
                3'd0: {oneshot_d, reload_d, irqen_d, en_d} = wmerge[3:0];
                3'd1: pre_d = wmerge[PRE_W-1:0];
                3'd2: cmp_d = wmerge[CNT_W-1:0];
                3'd3: cnt_d = wmerge[CNT_W-1:0];
                default: ;
            endcase
        end

        // A match set by a tick beats a same-cycle W1C.
        if (w1c && XATAI[0]) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end

        // The prescaler restarts from 0 whenever the timer is (or becomes) disabled.
        if (!en_d) begin
            psc_d = '0;
        end else if (run) begin
            psc_d = tick ? '0 : psc_q + PRE_W'(1);
        end
    end

`ifdef TIMER_CAPTURE_EN
    assign cap_rise = cap_sync_q[1] && !cap_sync_q[2];

    always_comb begin
        capt_d = cap_rise ? cnt_q : capt_q;
        capv_d = capv_q;
        if (w1c && XATAI[1]) begin
            capv_d = 1'b0;
        end
        if (cap_rise) begin
            capv_d = 1'b1;
        end
    end

    assign XIRQ = (match_q || capv_q) && irqen_q;
`else
    assign XIRQ = match_q && irqen_q;
`endif

    assign XDACK = ack_q;
    assign XATAO = rdata_q;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            irqen_q   <= 1'b0;
            reload_q  <= 1'b0;
            oneshot_q <= 1'b0;
            pre_q     <= '0;
            psc_q     <= '0;
            cmp_q     <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
`ifdef TIMER_CAPTURE_EN
            cap_sync_q <= '0;
            capt_q     <= '0;
            capv_q     <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (XDREQ) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                        rdata_q <= do_rd ? rmux : '0;
                    end
                end
                ACK: begin
                    state_q <= DONE;
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    // DONE: XDREQ is ignored for one turnaround cycle.
                    state_q <= IDLE;
                end
            endcase

            en_q      <= en_d;
            irqen_q   <= irqen_d;
            reload_q  <= reload_d;
            oneshot_q <= oneshot_d;
            pre_q     <= pre_d;
            psc_q     <= psc_d;
            cmp_q     <= cmp_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
`ifdef TIMER_CAPTURE_EN
            cap_sync_q <= {cap_sync_q[1:0], CAP_IN};
            capt_q     <= capt_d;
            capv_q     <= capv_d;
`endif
        end
    end

endmodule

// File: tb/tb_xbus_timer.sv
// -----------------------------------------------------------------------------
// tb_xbus_timer
//   Directed bench for xbus_timer. Inputs are driven and outputs sampled on
//   the falling clock edge. `cyc` counts rising edges, so at the falling edge
//   after rising edge N it reads N. Every expected value is worked out by
//   hand from the register behaviour.
// -----------------------------------------------------------------------------
module tb_xbus_timer;

    logic        CLK = 1'b0;
    logic        RES;
    logic        HLT;
    logic        XDREQ;
    logic        XRD;
    logic        XWR;
    logic [3:0]  XBE;
    logic [31:0] XADDR;
    logic [31:0] XATAI;
    logic [31:0] XATAO;
    logic        XDACK;
    logic        XIRQ;
    logic        CAP_IN;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int w_edge   = 0;
    int ew       = 0;

    localparam logic [2:0] R_CTRL = 3'd0;
    localparam logic [2:0] R_PRE  = 3'd1;
    localparam logic [2:0] R_CMP  = 3'd2;
    localparam logic [2:0] R_CNT  = 3'd3;
    localparam logic [2:0] R_STAT = 3'd4;
    localparam logic [2:0] R_CAPT = 3'd5;

    xbus_timer #(.CNT_W(32), .PRE_W(16)) dut (
        .CLK    (CLK),
        .RES    (RES),
        .HLT    (HLT),
        .XDREQ  (XDREQ),
        .XRD    (XRD),
        .XWR    (XWR),
        .XBE    (XBE),
        .XADDR  (XADDR),
        .XATAI  (XATAI),
        .XATAO  (XATAO),
        .XDACK  (XDACK),
        .XIRQ   (XIRQ),
        .CAP_IN (CAP_IN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. The request is sampled on the next rising
    // edge (E1), XDACK must be high after E1 and low after E2, and the task
    // returns after E3 with the FSM back in IDLE.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] ridx,
                          input logic [31:0] wdata, input logic [3:0] be, output logic [31:0] rdata);
        XDREQ = 1'b1;
        XRD   = rd;
        XWR   = wr;
        XADDR = {3'b110, 24'h0, ridx, 2'b01};
        XATAI = wdata;
        XBE   = be;
        @(negedge CLK);
        w_edge = cyc;
        check({tag, "_ack_on"}, {31'h0, XDACK}, 32'h1);
        rdata = XATAO;
        XDREQ = 1'b0;
        XRD   = 1'b0;
        XWR   = 1'b0;
        @(negedge CLK);
        check({tag, "_ack_off"}, {31'h0, XDACK}, 32'h0);
        @(negedge CLK);
    endtask

    task automatic wr(input string tag, input logic [2:0] ridx, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        access(tag, 1'b0, 1'b1, ridx, d, be, r);
        check({tag, "_xatao"}, r, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] ridx, input logic [31:0] exp);
        logic [31:0] r;
        access(tag, 1'b1, 1'b0, ridx, 32'hDEAD_BEEF, 4'h0, r);
        check(tag, r, exp);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic do_reset();
        RES = 1'b1;
        repeat (2) @(negedge CLK);
        RES = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        RES = 1'b1; HLT = 1'b0; XDREQ = 1'b0; XRD = 1'b0; XWR = 1'b0;
        XBE = 4'h0; XADDR = '0; XATAI = '0; CAP_IN = 1'b0;

        // ---- Reset state and all offsets read 0 ----
        repeat (2) @(negedge CLK);
        check("rst_xdack", {31'h0, XDACK}, 32'h0);
        check("rst_xatao", XATAO, 32'h0);
        check("rst_xirq", {31'h0, XIRQ}, 32'h0);
        RES = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("rst_rd%0d", i), 3'(i), 32'h0);
        end

        // ---- Periodic reload: PRESCALE=3, COMPARE=5, CTRL=EN|IRQEN|RELOAD ----
        wr("t2_pre", R_PRE, 32'd3, 4'hF);
        wr("t2_cmp", R_CMP, 32'd5, 4'hF);
        wr("t2_ctrl", R_CTRL, 32'h7, 4'hF);
        ew = w_edge;
        wait_to(ew + 23);
        check("t2_irq_pre", {31'h0, XIRQ}, 32'h0);
        wait_to(ew + 24);
        check("t2_irq_24", {31'h0, XIRQ}, 32'h1);
        wr("t2_w1c", R_STAT, 32'h1, 4'h1);
        check("t2_irq_clr", {31'h0, XIRQ}, 32'h0);
        rd_chk("t2_cnt_zero", R_CNT, 32'h0);
        wait_to(ew + 47);
        check("t2_irq_pre2", {31'h0, XIRQ}, 32'h0);
        wait_to(ew + 48);
        check("t2_irq_48", {31'h0, XIRQ}, 32'h1);

        // ---- Wrap: COUNT=FFFFFFFF, COMPARE=0x10, PRESCALE=0, EN only ----
        do_reset();
        wr("t3_cnt", R_CNT, 32'hFFFF_FFFF, 4'hF);
        rd_chk("t3_cnt_rb", R_CNT, 32'hFFFF_FFFF);
        wr("t3_cmp", R_CMP, 32'h10, 4'hF);
        wr("t3_ctrl", R_CTRL, 32'h1, 4'hF);
        ew = w_edge;
        rd_chk("t3_wrapped", R_CNT, 32'h1);
        wait_to(ew + 17);
        rd_chk("t3_no_match", R_STAT, 32'h0);
        rd_chk("t3_match", R_STAT, 32'h1);
        check("t3_irq_off", {31'h0, XIRQ}, 32'h0);

        // ---- One-shot: COMPARE=2, CTRL=ONESHOT|EN ----
        do_reset();
        wr("t4_cmp", R_CMP, 32'd2, 4'hF);
        wr("t4_ctrl", R_CTRL, 32'h9, 4'hF);
        ew = w_edge;
        rd_chk("t4_ctrl_run", R_CTRL, 32'h9);
        rd_chk("t4_cnt", R_CNT, 32'h3);
        rd_chk("t4_ctrl_off", R_CTRL, 32'h8);
        rd_chk("t4_stat", R_STAT, 32'h1);
        wait_to(ew + 30);
        rd_chk("t4_cnt_frozen", R_CNT, 32'h3);

        // ---- HLT freezes counting for exactly the HLT cycles ----
        do_reset();
        wr("t4h_cmp", R_CMP, 32'hFFFF, 4'hF);
        wr("t4h_ctrl", R_CTRL, 32'h1, 4'hF);
        ew = w_edge;
        HLT = 1'b1;
        rd_chk("t4h_cnt_hold", R_CNT, 32'h2);
        wait_to(ew + 12);
        HLT = 1'b0;
        wait_to(ew + 20);
        rd_chk("t4h_cnt_after", R_CNT, 32'd10);

        // ---- Byte enables, no-strobe access, both strobes, W1C vs match ----
        do_reset();
        wr("t5_be", R_CMP, 32'hAABB_CCDD, 4'b0010);
        rd_chk("t5_be_rb", R_CMP, 32'h0000_CC00);
        access("t5_nostrobe", 1'b0, 1'b0, R_CMP, 32'h1234_5678, 4'hF, r);
        check("t5_nostrobe_xatao", r, 32'h0);
        rd_chk("t5_nostrobe_rb", R_CMP, 32'h0000_CC00);
        access("t5_both", 1'b1, 1'b1, R_CMP, 32'd5, 4'hF, r);
        check("t5_both_xatao", r, 32'h0);
        rd_chk("t5_both_rb", R_CMP, 32'd5);
        wr("t5_ctrl", R_CTRL, 32'h3, 4'hF);
        ew = w_edge;
        wait_to(ew + 5);
        wr("t5_w1c_race", R_STAT, 32'h1, 4'h1);
        check("t5_race_irq", {31'h0, XIRQ}, 32'h1);
        rd_chk("t5_race_stat", R_STAT, 32'h1);
        wr("t5_w1c", R_STAT, 32'h1, 4'h1);
        check("t5_w1c_irq", {31'h0, XIRQ}, 32'h0);

        // ---- Capture input ----
        do_reset();
        wr("t6_cmp", R_CMP, 32'hFFFF, 4'hF);
        wr("t6_ctrl", R_CTRL, 32'h3, 4'hF);
        ew = w_edge;
        wait_to(ew + 64);
        CAP_IN = 1'b1;
        wait_to(ew + 65);
        CAP_IN = 1'b0;
`ifdef TIMER_CAPTURE_EN
        wait_to(ew + 66);
        check("t6_irq_pre", {31'h0, XIRQ}, 32'h0);
        wait_to(ew + 67);
        check("t6_irq_cap", {31'h0, XIRQ}, 32'h1);
        rd_chk("t6_capture", R_CAPT, 32'h42);
        rd_chk("t6_capv", R_STAT, 32'h2);
`else
        wait_to(ew + 70);
        check("t6_irq_nocap", {31'h0, XIRQ}, 32'h0);
        rd_chk("t6_capture_nocap", R_CAPT, 32'h0);
        rd_chk("t6_stat_nocap", R_STAT, 32'h0);
`endif

        // ---- Reset asserted mid-access: no XDACK, registers cleared ----
        wr("t6r_cmp", R_CMP, 32'h77, 4'hF);
        XDREQ = 1'b1;
        XRD   = 1'b1;
        XADDR = {27'h0, R_CMP, 2'b00};
        #2 RES = 1'b1;
        @(negedge CLK);
        check("t6r_ack1", {31'h0, XDACK}, 32'h0);
        check("t6r_xatao", XATAO, 32'h0);
        @(negedge CLK);
        check("t6r_ack2", {31'h0, XDACK}, 32'h0);
        XDREQ = 1'b0;
        XRD   = 1'b0;
        RES   = 1'b0;
        @(negedge CLK);
        check("t6r_ack3", {31'h0, XDACK}, 32'h0);
        rd_chk("t6r_cmp_cleared", R_CMP, 32'h0);
        rd_chk("t6r_ctrl_cleared", R_CTRL, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
